// File: rtl/mux_serializer_8_pkg.sv
// Shared constants and state encoding for the 8-bit parallel-in/serial-out stage.
package mux_serializer_8_pkg;

  localparam int WORD_W = 8;
  localparam int IDX_W  = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : mux_serializer_8_pkg

// File: rtl/MUX_8x1.sv
// 8-to-1 bit multiplexer: picks data_i[sel_i]. Purely combinational.
module MUX_8x1
  import mux_serializer_8_pkg::*;
(
  input  logic [WORD_W-1:0] data_i,
  input  logic [IDX_W-1:0]  sel_i,
  output logic              y_o
);

  always_comb begin
    y_o = 1'b0;
    case (sel_i)
      3'd0: y_o = data_i[0];
      3'd1: y_o = data_i[1];
      3'd2: y_o = data_i[2];
      3'd3: y_o = data_i[3];
      3'd4: y_o = data_i[4];
      3'd5: y_o = data_i[5];
      3'd6: y_o = data_i[6];
      3'd7: y_o = data_i[7];
      default: y_o = 1'b0;
    endcase
  end

endmodule : MUX_8x1

// File: rtl/mux_serializer_8.sv
// Accepts an 8-bit word over valid/ready and emits it one bit per cycle through MUX_8x1.
// Handshakes: a transfer happens on a cycle where valid && ready are both high at the rising edge.
module mux_serializer_8
  import mux_serializer_8_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ser_valid,
  input  logic              ser_ready,
  output logic              ser_out,
  output logic              ser_last,
  output logic              busy
);

  state_e             state_q;
  logic [WORD_W-1:0]  word_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   sel;
  logic               at_last;
  logic               bit_xfer;

  assign at_last  = (cnt_q == LAST_IDX);
  assign bit_xfer = (state_q == ST_SHIFT) && ser_ready;

  // ser_ready -> in_ready is combinational so a new word can load on the 8th-bit cycle.
  assign in_ready  = !flush && ((state_q == ST_IDLE) || (at_last && bit_xfer));
  assign ser_valid = (state_q == ST_SHIFT);
  assign busy      = (state_q == ST_SHIFT);
  assign ser_last  = (state_q == ST_SHIFT) && at_last;

  assign sel = LSB_FIRST ? cnt_q : ~cnt_q;

  MUX_8x1 u_mux (
    .data_i (word_q),
    .sel_i  (sel),
    .y_o    (ser_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
    end else if (flush) begin
      // word_q is kept on purpose; only the sequencing is aborted.
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            word_q  <= in_data;
            cnt_q   <= '0;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ser_ready) begin
            if (!at_last) begin
              cnt_q <= cnt_q + 3'd1;
            end else if (in_valid) begin
              word_q <= in_data;
              cnt_q  <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule : mux_serializer_8

// File: tb/tb_mux_serializer_8.sv
// Bench for mux_serializer_8: both bit orders side by side against a bit-queue model.
module tb_mux_serializer_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       ser_ready = 1'b1;

  logic in_ready_l, ser_valid_l, ser_out_l, ser_last_l, busy_l;
  logic in_ready_m, ser_valid_m, ser_out_m, ser_last_m, busy_m;

  int vectors = 0;
  int miscompares = 0;

  // Model: bits still owed downstream, in emission order.
  logic exp_q_l[$];
  logic exp_q_m[$];
  logic [15:0] seq_l, seq_m;
  int vcnt;
  int irc;
  logic exp_ir, xfer;

  always #5 clk = ~clk;

  mux_serializer_8 #(.LSB_FIRST(1'b1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_l), .ser_valid(ser_valid_l), .ser_ready(ser_ready),
    .ser_out(ser_out_l), .ser_last(ser_last_l), .busy(busy_l)
  );

  mux_serializer_8 #(.LSB_FIRST(1'b0)) u_msb (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_m), .ser_valid(ser_valid_m), .ser_ready(ser_ready),
    .ser_out(ser_out_m), .ser_last(ser_last_m), .busy(busy_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " in_ready_l"},  in_ready_l,  1);
    chk({tag, " ser_valid_l"}, ser_valid_l, 0);
    chk({tag, " ser_last_l"},  ser_last_l,  0);
    chk({tag, " busy_l"},      busy_l,      0);
    chk({tag, " ser_out_l"},   ser_out_l,   0);
    chk({tag, " in_ready_m"},  in_ready_m,  1);
    chk({tag, " ser_valid_m"}, ser_valid_m, 0);
    chk({tag, " ser_out_m"},   ser_out_m,   0);
  endtask

  // Compare process: outputs are checked mid-cycle, then the model advances
  // using the same input values the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q_l.delete();
      exp_q_m.delete();
      chk_reset_vals("rst");
    end else begin
      exp_ir = !flush && (exp_q_l.size() == 0 || (exp_q_l.size() == 1 && ser_ready));
      chk("in_ready_l",  in_ready_l,  exp_ir);
      chk("in_ready_m",  in_ready_m,  exp_ir);
      chk("ser_valid_l", ser_valid_l, exp_q_l.size() != 0);
      chk("ser_valid_m", ser_valid_m, exp_q_m.size() != 0);
      chk("busy_l",      busy_l,      exp_q_l.size() != 0);
      chk("ser_last_l",  ser_last_l,  exp_q_l.size() == 1);
      chk("ser_last_m",  ser_last_m,  exp_q_m.size() == 1);
      if (exp_q_l.size() != 0) chk("ser_out_l", ser_out_l, exp_q_l[0]);
      if (exp_q_m.size() != 0) chk("ser_out_m", ser_out_m, exp_q_m[0]);
      if (exp_q_l.size() != 0) vcnt++;
      if (exp_q_l.size() != 0 && in_ready_l) irc++;

      xfer = (exp_q_l.size() != 0) && ser_ready;
      if (flush) begin
        exp_q_l.delete();
        exp_q_m.delete();
      end else begin
        if (xfer) begin
          seq_l = {seq_l[14:0], ser_out_l};
          seq_m = {seq_m[14:0], ser_out_m};
          void'(exp_q_l.pop_front());
          void'(exp_q_m.pop_front());
        end
        if (in_valid && exp_ir) begin
          for (int i = 0; i < 8; i++) begin
            exp_q_l.push_back(in_data[i]);
            exp_q_m.push_back(in_data[7-i]);
          end
        end
      end
    end
  end

  // Present a word and hold it until the accepting edge has passed.
  task automatic send(input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready_l) begin
        ok = 1'b1;
        break;
      end
    end
    chk("send accepted", ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_q_l.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle bound", ok, 1);
  endtask

  task automatic clear_logs();
    seq_l = '0;
    seq_m = '0;
    vcnt  = 0;
    irc   = 0;
  endtask

  initial begin
    clear_logs();
    #12;
    chk_reset_vals("init");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // LSB-first / MSB-first single word A5.
    clear_logs();
    send(8'hA5);
    in_valid = 1'b0;
    wait_idle();
    chk("A5 seq_l", seq_l[7:0], 8'hA5);
    chk("A5 seq_m", seq_m[7:0], 8'hA5);
    chk("A5 valid cycles", vcnt, 8);

    // 0F: LSB-first gives 1111_0000, MSB-first gives 0000_1111.
    clear_logs();
    send(8'h0F);
    in_valid = 1'b0;
    wait_idle();
    chk("0F seq_l", seq_l[7:0], 8'hF0);
    chk("0F seq_m", seq_m[7:0], 8'h0F);

    // Back-to-back 0F then F0 with in_valid held.
    clear_logs();
    send(8'h0F);
    send(8'hF0);
    in_valid = 1'b0;
    wait_idle();
    chk("b2b seq_l", seq_l, 16'hF00F);
    chk("b2b seq_m", seq_m, 16'h0FF0);
    chk("b2b valid cycles", vcnt, 16);
    chk("b2b in_ready pulses", irc, 2);

    // Backpressure for 3 cycles at bit index 3.
    clear_logs();
    send(8'hA5);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    ser_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stall ser_out_l", ser_out_l, 0);
      chk("stall ser_out_m", ser_out_m, 0);
      chk("stall ser_valid_l", ser_valid_l, 1);
    end
    ser_ready = 1'b1;
    wait_idle();
    chk("stall seq_l", seq_l[7:0], 8'hA5);
    chk("stall seq_m", seq_m[7:0], 8'hA5);
    chk("stall valid cycles", vcnt, 11);

    // Asynchronous reset at bit 4 of FF, then 01.
    clear_logs();
    send(8'hFF);
    in_valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(negedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    send(8'h01);
    in_valid = 1'b0;
    chk("post-reset first bit_l", ser_out_l, 1);
    chk("post-reset first bit_m", ser_out_m, 0);
    wait_idle();
    chk("01 seq_l", seq_l[7:0], 8'h80);
    chk("01 seq_m", seq_m[7:0], 8'h01);

    // Flush at bit 2 with a competing word 3C.
    send(8'hA5);
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h3C;
    #1 chk("flush in_ready", in_ready_l, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("after flush ser_valid", ser_valid_l, 0);
    chk("after flush busy", busy_m, 0);
    chk("after flush in_ready", in_ready_l, 1);
    clear_logs();
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("3C accepted", ser_valid_l, 1);
    wait_idle();
    chk("3C seq_l", seq_l[7:0], 8'h3C);
    chk("3C seq_m", seq_m[7:0], 8'h3C);
    chk("3C valid cycles", vcnt, 8);

    // Flush in IDLE also blocks acceptance.
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("idle flush no accept", ser_valid_l, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mux_serializer_8
